// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter sizing helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must index bits 0..width-1; width is at least 2.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: difference and borrow-out for x - y - bin.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, with the
// borrow carried in a register between bits.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    count;
    logic             br;
    logic             bout_r;
    logic             accept;
    logic             last;
    logic             bit_d;
    logic             bit_bo;

    full_subtractor u_cell (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (br),
        .d   (bit_d),
        .bo  (bit_bo)
    );

    assign last = (count == LAST);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) state_next = ST_DONE;
            end
            ST_DONE: begin
                // A start in the done cycle is accepted back-to-back.
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            diff_r <= '0;
            count  <= '0;
            br     <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                br    <= 1'b0;
                count <= '0;
            end else if (state == ST_RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                diff_r <= {bit_d, diff_r[WIDTH-1:1]};
                br     <= bit_bo;
                count  <= count + 1'b1;
                if (last) bout_r <= bit_bo;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign diff = diff_r;
    assign bout = bout_r;

endmodule
